binconv_engine: RTL and testbench

Parametrised binary-convolution engine. Streams square binary images row by row from the input SRAM and convolves each with its own K×K binary kernel from the weight SRAM using XNOR-popcount with a majority threshold. Writes one packed output row per cycle back to the SRAM. It is the next-generation core of the binary-convolution top level: it adds kernel size, width, threshold and multi-image sequencing with a per-image kernel index.

---
 rtl/binconv_engine_pkg.sv | 22 ++
 rtl/binconv_engine_if.sv | 28 ++
 rtl/binconv_engine_row.sv | 49 ++++
 rtl/binconv_engine.sv | 171 +++++++++++++++++
 tb/tb_binconv_engine.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/binconv_engine_pkg.sv
// Shared types and elaboration helpers for the binary-convolution engine.
// Holds the FSM encoding, popcount sizing and parameter legality rule.
package binconv_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DIM,
      S_FILL,
      S_STREAM,
      S_SKIP,
      S_DONE
   } state_e;

   function automatic int pc_width(input int k);
      return $clog2(k * k + 1);
   endfunction

   function automatic bit params_legal(input int data_w, input int k);
      return (k >= 3) && ((k % 2) == 1) && ((k * k) <= data_w);
   endfunction

endpackage

// File: rtl/binconv_engine_if.sv
// Memory-side bus of the engine: start/busy, image read, kernel read, row write.
// master = engine, slave = memories/host.
interface binconv_engine_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12
);
   logic              dut_run;
   logic              dut_busy;
   logic [ADDR_W-1:0] dut_sram_read_address;
   logic [DATA_W-1:0] sram_dut_read_data;
   logic [ADDR_W-1:0] dut_wmem_read_address;
   logic [DATA_W-1:0] wmem_dut_read_data;
   logic [ADDR_W-1:0] dut_sram_write_address;
   logic [DATA_W-1:0] dut_sram_write_data;
   logic              dut_sram_write_enable;

   modport master (
      input  dut_run, sram_dut_read_data, wmem_dut_read_data,
      output dut_busy, dut_sram_read_address, dut_wmem_read_address,
      output dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
   );

   modport slave (
      output dut_run, sram_dut_read_data, wmem_dut_read_data,
      input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
      input  dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
   );
endinterface

// File: rtl/binconv_engine_row.sv
// Combinational XNOR-popcount of one K-row window across all columns.
// Columns beyond N-K (or every column when N<K) are forced to 0.
module binconv_row
   import binconv_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int K      = 3,
   parameter int THRESH = (K * K + 1) / 2,
   parameter int CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic [DATA_W-1:0] rows_i [K],
   input  logic [DATA_W-1:0] kern_i,
   input  logic [CNT_W-1:0]  n_i,
   output logic [DATA_W-1:0] row_o
);
   localparam int PC_W  = pc_width(K);
   localparam int EXT_W = DATA_W + K - 1;

   logic [EXT_W-1:0] ext [K];
   logic [PC_W-1:0]  pc;

   always_comb begin
      row_o = '0;
      pc    = '0;
      // Zero-extend so the window never indexes past the row for masked columns.
      for (int r = 0; r < K; r++) begin
         ext[r] = {{(K-1){1'b0}}, rows_i[r]};
      end
      for (int c = 0; c < DATA_W; c++) begin
         pc = '0;
         for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
               if (ext[r][c+k] ~^ kern_i[r*K+k]) begin
                  pc = pc + PC_W'(1);
               end
            end
         end
         if (((c + K) <= int'(n_i)) && (pc >= PC_W'(THRESH))) begin
            row_o[c] = 1'b1;
         end
      end
   end

   if (K * K < DATA_W) begin : g_kern_hi
      logic unused_kern_hi;
      assign unused_kern_hi = ^kern_i[DATA_W-1:K*K];
   end

endmodule

// File: rtl/binconv_engine.sv
// Binary-convolution engine: sequences images from SRAM, one output row per streamed row.
// Read addresses advance every busy cycle; the dimension word costs one row-less cycle.
module binconv_engine
   import binconv_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int K      = 3,
   parameter int THRESH = (K * K + 1) / 2
) (
   input  logic             clk,
   input  logic             reset_b,
   binconv_engine_if.master bus
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   if (!params_legal(DATA_W, K)) begin : g_bad_params
      $error("binconv_engine: K must be odd, >= 3, and K*K <= DATA_W");
   end

   state_e            state_q, state_d;
   logic              dim_wait_q, dim_wait_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] wt_ptr_q, wt_ptr_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] kern_q, kern_d;
   logic [DATA_W-1:0] lb_q [K];
   logic [DATA_W-1:0] lb_d [K];
   logic              wr_en_q, wr_en_d;
   logic [DATA_W-1:0] rd_dat;
   logic [DATA_W-1:0] row_dat;

   assign rd_dat = bus.sram_dut_read_data;

   binconv_row #(
      .DATA_W (DATA_W),
      .K      (K),
      .THRESH (THRESH),
      .CNT_W  (CNT_W)
   ) u_row (
      .rows_i (lb_q),
      .kern_i (kern_q),
      .n_i    (n_q),
      .row_o  (row_dat)
   );

   always_comb begin
      state_d    = state_q;
      dim_wait_d = dim_wait_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      wt_ptr_d   = wt_ptr_q;
      n_d        = n_q;
      row_d      = row_q;
      kern_d     = kern_q;
      lb_d       = lb_q;
      wr_en_d    = 1'b0;

      if (wr_en_q) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (bus.dut_run) begin
               state_d    = S_DIM;
               dim_wait_d = 1'b1;
               rd_ptr_d   = '0;
               wr_ptr_d   = '0;
               wt_ptr_d   = '0;
            end
         end
         S_DIM: begin
            // First DIM of a run waits one cycle for address 0 to return data.
            if (dim_wait_q) begin
               dim_wait_d = 1'b0;
               rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            end else begin
               row_d = '0;
               n_d   = rd_dat[CNT_W-1:0];
               for (int j = 0; j < K; j++) begin
                  lb_d[j] = '0;
               end
               if (rd_dat > DATA_W'(DATA_W)) begin
                  state_d  = S_DONE;
                  rd_ptr_d = '0;
               end else if (rd_dat < DATA_W'(K)) begin
                  // Row 0 is already in flight; jumping by N lands on the next dimension word.
                  state_d  = S_SKIP;
                  rd_ptr_d = rd_ptr_q + ADDR_W'(rd_dat[CNT_W-1:0]);
               end else begin
                  state_d  = S_FILL;
                  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               end
            end
         end
         S_FILL, S_STREAM: begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            row_d    = row_q + CNT_W'(1);
            for (int j = 0; j < K - 1; j++) begin
               lb_d[j] = lb_q[j+1];
            end
            lb_d[K-1] = rd_dat;
            if (state_q == S_FILL) begin
               if (row_q == '0) begin
                  kern_d = bus.wmem_dut_read_data;
               end
               if (row_q == CNT_W'(K - 2)) begin
                  state_d = S_STREAM;
               end
            end else begin
               wr_en_d = 1'b1;
               if (row_q == n_q - CNT_W'(1)) begin
                  state_d  = S_DIM;
                  wt_ptr_d = wt_ptr_q + ADDR_W'(1);
               end
            end
         end
         S_SKIP: begin
            state_d  = S_DIM;
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            wt_ptr_d = wt_ptr_q + ADDR_W'(1);
         end
         S_DONE: begin
            state_d  = S_IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            wt_ptr_d = '0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state_q    <= S_IDLE;
         dim_wait_q <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         wt_ptr_q   <= '0;
         n_q        <= '0;
         row_q      <= '0;
         kern_q     <= '0;
         wr_en_q    <= 1'b0;
         for (int j = 0; j < K; j++) begin
            lb_q[j] <= '0;
         end
      end else begin
         state_q    <= state_d;
         dim_wait_q <= dim_wait_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         wt_ptr_q   <= wt_ptr_d;
         n_q        <= n_d;
         row_q      <= row_d;
         kern_q     <= kern_d;
         wr_en_q    <= wr_en_d;
         lb_q       <= lb_d;
      end
   end

   assign bus.dut_busy               = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.dut_sram_read_address  = rd_ptr_q;
   assign bus.dut_wmem_read_address  = wt_ptr_q;
   assign bus.dut_sram_write_address = wr_ptr_q;
   assign bus.dut_sram_write_enable  = wr_en_q;
   assign bus.dut_sram_write_data    = wr_en_q ? row_dat : '0;

endmodule

// File: tb/tb_binconv_engine.sv
// Directed bench for binconv_engine with synchronous SRAM/WMEM models and a write log.
module tb_binconv_engine;
   localparam int KT = 3;
   localparam int TH = 5;

   logic clk = 1'b0;
   logic reset_b;
   always #5 clk = ~clk;

   binconv_engine_if #(.DATA_W(16), .ADDR_W(12)) bus ();

   binconv_engine #(.DATA_W(16), .ADDR_W(12), .K(3)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .bus     (bus)
   );

   logic [15:0] sram_m [64];
   logic [15:0] wmem_m [8];

   always @(posedge clk) begin
      bus.sram_dut_read_data <= sram_m[bus.dut_sram_read_address[5:0]];
      bus.wmem_dut_read_data <= wmem_m[bus.dut_wmem_read_address[2:0]];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;
   int viol   = 0;
   int c1     = 0;
   logic [11:0] log_addr [$];
   logic [15:0] log_dat [$];
   logic [11:0] log_wa [$];
   int          log_cyc [$];
   logic [15:0] exp_dat [$];
   logic [15:0] img_a [16];
   logic [15:0] img_b [16];
   logic [15:0] img_c [16];
   logic [15:0] img_d [16];

   always @(negedge clk) begin
      if (bus.dut_sram_write_enable === 1'b1) begin
         log_addr.push_back(bus.dut_sram_write_address);
         log_dat.push_back(bus.dut_sram_write_data);
         log_wa.push_back(bus.dut_wmem_read_address);
         log_cyc.push_back(cyc);
         if (bus.dut_busy !== 1'b1) viol++;
      end
   end

   function automatic logic [15:0] model_row(input logic [15:0] img[16], input int n,
                                             input logic [15:0] kern, input int r);
      logic [15:0] o;
      int cnt;
      o = 16'h0000;
      for (int c = 0; c + KT <= n; c++) begin
         cnt = 0;
         for (int i = 0; i < KT; i++)
            for (int j = 0; j < KT; j++)
               if (img[r+i][c+j] == kern[i*KT+j]) cnt++;
         o[c] = (cnt >= TH);
      end
      return o;
   endfunction

   task automatic add_expect(input logic [15:0] img[16], input int n, input logic [15:0] kern);
      for (int r = 0; r + KT <= n; r++) exp_dat.push_back(model_row(img, n, kern, r));
   endtask

   task automatic load_image(input int base, input logic [15:0] img[16], input int n);
      sram_m[base] = 16'(n);
      for (int i = 0; i < n; i++) sram_m[base+1+i] = img[i];
   endtask

   task automatic clear_all();
      for (int i = 0; i < 64; i++) sram_m[i] = 16'hFFFF;
      for (int i = 0; i < 8; i++) wmem_m[i] = 16'h0000;
      log_addr.delete(); log_dat.delete(); log_wa.delete(); log_cyc.delete();
      exp_dat.delete();
      viol = 0;
   endtask

   task automatic start_run(input string name);
      @(negedge clk); bus.dut_run = 1'b1;
      @(negedge clk); bus.dut_run = 1'b0;
      c1 = cyc;
      n_cmp++;
      if (bus.dut_busy !== 1'b1 || bus.dut_sram_read_address !== 12'd0) begin
         n_fail++;
         $display("FAIL %s start: busy=%b raddr=%0d, required busy=1 raddr=0",
                  name, bus.dut_busy, bus.dut_sram_read_address);
      end
   endtask

   task automatic wait_done(input string name, output int fall_cyc);
      int k;
      k = 0;
      while (bus.dut_busy === 1'b1 && k < 2000) begin
         @(negedge clk); k++;
      end
      fall_cyc = cyc;
      n_cmp++;
      if (bus.dut_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", name, bus.dut_busy, k);
      end
   endtask

   task automatic test_reset();
      logic [53:0] outs;
      reset_b = 1'b0;
      bus.dut_run = 1'b1;
      repeat (3) begin
         @(negedge clk);
         outs = {bus.dut_busy, bus.dut_sram_write_enable, bus.dut_sram_read_address,
                 bus.dut_wmem_read_address, bus.dut_sram_write_address, bus.dut_sram_write_data};
         n_cmp++;
         if (outs !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
         end
      end
      bus.dut_run = 1'b0;
      reset_b = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.dut_busy !== 1'b0 || log_dat.size() != 0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b writes=%0d, required busy=0 writes=0",
                  bus.dut_busy, log_dat.size());
      end
   endtask

   task automatic test_all_ones();
      int fall;
      clear_all();
      sram_m[0] = 16'd4;
      for (int i = 1; i <= 4; i++) sram_m[i] = 16'h000F;
      sram_m[5] = 16'hFFFF;
      wmem_m[0] = 16'h01FF;
      start_run("all_ones");
      wait_done("all_ones", fall);
      n_cmp++;
      if (fall != c1 + 7) begin
         n_fail++; $display("FAIL all_ones busy_fall: cycle %0d, required %0d", fall - c1, 7);
      end
      n_cmp++;
      if (log_dat.size() != 2) begin
         n_fail++; $display("FAIL all_ones count: %0d writes, required 2", log_dat.size());
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (i >= log_dat.size() || log_dat[i] !== 16'h0003 || log_addr[i] !== 12'(i)) begin
            n_fail++; $display("FAIL all_ones row%0d: got incorrect write, required addr %0d data 0003", i, i);
         end
      end
      n_cmp++;
      if (log_cyc.size() == 0 || log_cyc[0] != c1 + 5) begin
         n_fail++; $display("FAIL all_ones latency: first write cycle wrong, required %0d", 5);
      end
      n_cmp++;
      if (viol != 0) begin
         n_fail++; $display("FAIL all_ones we_idle: %0d, required 0", viol);
      end
   endtask

   task automatic test_zero_kernel();
      int fall;
      clear_all();
      sram_m[0] = 16'd4;
      for (int i = 1; i <= 4; i++) sram_m[i] = 16'h000F;
      sram_m[5] = 16'hFFFF;
      wmem_m[0] = 16'h0000;
      start_run("zero_kern");
      wait_done("zero_kern", fall);
      n_cmp++;
      if (log_dat.size() != 2) begin
         n_fail++; $display("FAIL zero_kern count: %0d writes, required 2", log_dat.size());
      end
      for (int i = 0; i < log_dat.size(); i++) begin
         n_cmp++;
         if (log_dat[i] !== 16'h0000 || log_addr[i] !== 12'(i)) begin
            n_fail++; $display("FAIL zero_kern row%0d: addr %0d data %h, required addr %0d data 0000",
                               i, log_addr[i], log_dat[i], i);
         end
      end
   endtask

   task automatic test_two_images();
      int fall;
      clear_all();
      load_image(0, img_a, 16);
      load_image(17, img_b, 5);
      wmem_m[0] = 16'hA4BA;
      wmem_m[1] = 16'h7E55;
      add_expect(img_a, 16, 16'hA4BA);
      add_expect(img_b, 5, 16'h7E55);
      start_run("two_img");
      wait_done("two_img", fall);
      n_cmp++;
      if (log_dat.size() != 17) begin
         n_fail++; $display("FAIL two_img count: %0d writes, required 17", log_dat.size());
      end
      for (int i = 0; i < 17; i++) begin
         n_cmp++;
         if (i >= log_dat.size() || log_dat[i] !== exp_dat[i] || log_addr[i] !== 12'(i)) begin
            n_fail++; $display("FAIL two_img row%0d: wrong write, required addr %0d data %h", i, i, exp_dat[i]);
         end
      end
      n_cmp++;
      if (log_wa.size() < 15 || log_wa[0] !== 12'd0 || log_wa[14] !== 12'd1) begin
         n_fail++; $display("FAIL two_img wmem_addr: wrong kernel index during image writes, required 0 then 1");
      end
      n_cmp++;
      if (viol != 0) begin
         n_fail++; $display("FAIL two_img we_idle: %0d, required 0", viol);
      end
   endtask

   task automatic test_undersized();
      int fall;
      clear_all();
      load_image(0, img_c, 4);
      load_image(5, img_b, 2);
      load_image(8, img_d, 4);
      wmem_m[0] = 16'h0155;
      wmem_m[1] = 16'h01FF;
      wmem_m[2] = 16'h00C7;
      add_expect(img_c, 4, 16'h0155);
      add_expect(img_d, 4, 16'h00C7);
      start_run("undersized");
      wait_done("undersized", fall);
      n_cmp++;
      if (log_dat.size() != 4) begin
         n_fail++; $display("FAIL undersized count: %0d writes, required 4", log_dat.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= log_dat.size() || log_dat[i] !== exp_dat[i] || log_addr[i] !== 12'(i)) begin
            n_fail++; $display("FAIL undersized row%0d: wrong write, required addr %0d data %h", i, i, exp_dat[i]);
         end
      end
      n_cmp++;
      if (log_wa.size() < 3 || log_wa[2] !== 12'd2) begin
         n_fail++; $display("FAIL undersized wmem_addr: third image kernel index wrong, required 2");
      end
   endtask

   task automatic test_reset_mid_run();
      int fall;
      logic [53:0] outs;
      clear_all();
      load_image(0, img_a, 16);
      load_image(17, img_b, 5);
      wmem_m[0] = 16'hA4BA;
      wmem_m[1] = 16'h7E55;
      add_expect(img_a, 16, 16'hA4BA);
      add_expect(img_b, 5, 16'h7E55);
      start_run("mid_reset");
      repeat (8) @(negedge clk);
      reset_b = 1'b0;
      @(posedge clk); #1;
      log_addr.delete(); log_dat.delete(); log_wa.delete(); log_cyc.delete();
      @(negedge clk);
      outs = {bus.dut_busy, bus.dut_sram_write_enable, bus.dut_sram_read_address,
              bus.dut_wmem_read_address, bus.dut_sram_write_address, bus.dut_sram_write_data};
      n_cmp++;
      if (outs !== 54'd0) begin
         n_fail++; $display("FAIL mid_reset outputs: got %h, required 0", outs);
      end
      reset_b = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (log_dat.size() != 0 || bus.dut_busy !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset partial: writes=%0d busy=%b, required 0 and 0",
                            log_dat.size(), bus.dut_busy);
      end
      start_run("restart");
      repeat (3) @(negedge clk);
      bus.dut_run = 1'b1;
      @(negedge clk);
      bus.dut_run = 1'b0;
      wait_done("restart", fall);
      n_cmp++;
      if (log_dat.size() != 17) begin
         n_fail++; $display("FAIL restart count: %0d writes, required 17", log_dat.size());
      end
      for (int i = 0; i < 17; i++) begin
         n_cmp++;
         if (i >= log_dat.size() || log_dat[i] !== exp_dat[i] || log_addr[i] !== 12'(i)) begin
            n_fail++; $display("FAIL restart row%0d: wrong write, required addr %0d data %h", i, i, exp_dat[i]);
         end
      end
      repeat (4) @(negedge clk);
      n_cmp++;
      if (bus.dut_busy !== 1'b0 || log_dat.size() != 17) begin
         n_fail++; $display("FAIL restart extra_start: busy=%b writes=%0d, required 0 and 17",
                            bus.dut_busy, log_dat.size());
      end
   endtask

   initial begin
      img_a = '{16'hA5C3, 16'h3C5A, 16'hFF00, 16'h0F0F, 16'h1234, 16'hF00D, 16'hBEEF, 16'h5555,
                16'hAAAA, 16'h0001, 16'h8000, 16'hC3A5, 16'h7E7E, 16'h9999, 16'h6666, 16'hDEAD};
      img_b = '{0: 16'hFFF3, 1: 16'h0014, 2: 16'h800B, 3: 16'h0019, 4: 16'h7FE6, default: 16'h0000};
      img_c = '{0: 16'h0009, 1: 16'hF006, 2: 16'h000F, 3: 16'h0003, default: 16'h0000};
      img_d = '{0: 16'h000C, 1: 16'h0005, 2: 16'hAAAE, 3: 16'h0001, default: 16'h0000};
      bus.dut_run = 1'b0;
      reset_b = 1'b0;
      for (int i = 0; i < 64; i++) sram_m[i] = 16'hFFFF;
      for (int i = 0; i < 8; i++) wmem_m[i] = 16'h0000;
      test_reset();
      test_all_ones();
      test_zero_kernel();
      test_two_images();
      test_undersized();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
